// File: rtl/cnn_pxl_stream_src_pkg.sv
// Shared types and sizing helpers for the CNN pixel stream source.
package cnn_pxl_stream_src_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter width for a range of n values, never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_stream_addr_gen.sv
// Column/row/channel counters and a running read address for a channel-major frame.
module cnn_stream_addr_gen
    import cnn_pxl_stream_src_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_in_channel,
    output logic                  last_in_frame
);

    localparam int COL_CNT_W = cnt_w(IMAGE_WIDTH);
    localparam int ROW_CNT_W = cnt_w(IMAGE_HEIGHT);
    localparam int CH_CNT_W  = cnt_w(CHANNEL_NUM);

    localparam logic [COL_CNT_W-1:0] COL_MAX = COL_CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_CNT_W-1:0] ROW_MAX = ROW_CNT_W'(IMAGE_HEIGHT - 1);
    localparam logic [CH_CNT_W-1:0]  CH_MAX  = CH_CNT_W'(CHANNEL_NUM - 1);

    logic [COL_CNT_W-1:0] col;
    logic [ROW_CNT_W-1:0] row;
    logic [CH_CNT_W-1:0]  ch;
    logic                 col_last, row_last, ch_last;

    assign col_last        = (col == COL_MAX);
    assign row_last        = (row == ROW_MAX);
    assign ch_last         = (ch == CH_MAX);
    assign last_in_channel = col_last && row_last;
    assign last_in_frame   = last_in_channel && ch_last;

    // Address tracks ch*W*H + row*W + col by incrementing alongside the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= last_in_frame ? '0 : addr + 1'b1;
            col  <= col_last ? '0 : col + 1'b1;
            if (col_last) begin
                row <= row_last ? '0 : row + 1'b1;
                if (row_last)
                    ch <= ch_last ? '0 : ch + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_pxl_stream_src.sv
// Frame sequencer and output pipeline turning a synchronous-read memory into a valid/pxl stream.
module cnn_pxl_stream_src
    import cnn_pxl_stream_src_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512,
    parameter int ADDR_WIDTH   = 17,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int GAP_CNT_W  = cnt_w(GAP_CYCLES);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

    state_t               state, state_nxt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 drain_cnt;
    logic                 step, clear;
    logic                 last_in_channel, last_in_frame;
    logic                 rd_en_d1;

    cnn_stream_addr_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .CHANNEL_NUM (CHANNEL_NUM),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_gen (
        .clk            (clk),
        .reset          (reset),
        .step           (step),
        .clear          (clear),
        .addr           (mem_addr),
        .last_in_channel(last_in_channel),
        .last_in_frame  (last_in_frame)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            drain_cnt <= (state == DRAIN);
        end
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        clear     = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!pause) begin
                    mem_rd_en = 1'b1;
                    step      = 1'b1;
                    if (last_in_frame)
                        state_nxt = DRAIN;
                    else if (last_in_channel && GAP_CYCLES > 0)
                        state_nxt = GAP;
                end
            end
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = RUN;
            // Two cycles let the final read cross the memory and output registers.
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == GAP) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_d1  <= 1'b0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            rd_en_d1  <= mem_rd_en;
            valid_out <= rd_en_d1;
            if (rd_en_d1)
                pxl_out <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cnn_pxl_stream_src.sv
// Directed bench for cnn_pxl_stream_src: three geometries, memory returns data = address.
module tb_cnn_pxl_stream_src;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: 4x4x2, no gap
    logic        start_a, pause_a, rd_a, valid_a, busy_a, done_a;
    logic [4:0]  addr_a;
    logic [31:0] rdata_a, pxl_a;
    // DUT B: 4x4x2, 3-cycle gap
    logic        start_b, pause_b, rd_b, valid_b, busy_b, done_b;
    logic [4:0]  addr_b;
    logic [31:0] rdata_b, pxl_b;
    // DUT C: 1x1x1
    logic        start_c, pause_c, rd_c, valid_c, busy_c, done_c;
    logic [0:0]  addr_c;
    logic [31:0] rdata_c, pxl_c;

    cnn_pxl_stream_src #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(2),
                         .ADDR_WIDTH(5), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pause(pause_a), .mem_rd_en(rd_a),
        .mem_addr(addr_a), .mem_rdata(rdata_a), .pxl_out(pxl_a), .valid_out(valid_a),
        .busy(busy_a), .done(done_a));

    cnn_pxl_stream_src #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(2),
                         .ADDR_WIDTH(5), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pause(pause_b), .mem_rd_en(rd_b),
        .mem_addr(addr_b), .mem_rdata(rdata_b), .pxl_out(pxl_b), .valid_out(valid_b),
        .busy(busy_b), .done(done_b));

    cnn_pxl_stream_src #(.DATA_WIDTH(32), .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .CHANNEL_NUM(1),
                         .ADDR_WIDTH(1), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .pause(pause_c), .mem_rd_en(rd_c),
        .mem_addr(addr_c), .mem_rdata(rdata_c), .pxl_out(pxl_c), .valid_out(valid_c),
        .busy(busy_c), .done(done_c));

    always @(posedge clk) begin
        if (rd_a) rdata_a <= 32'(addr_a);
        if (rd_b) rdata_b <= 32'(addr_b);
        if (rd_c) rdata_c <= 32'(addr_c);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int qa[$], ta[$], qb[$], tb[$], qc[$], tc[$];
    int dn_a = 0, dn_b = 0, dn_c = 0;
    int dcyc_a = 0, dcyc_b = 0, dcyc_c = 0;
    int bsy_a = 0;

    always @(negedge clk) begin
        if (valid_a) begin qa.push_back(int'(pxl_a)); ta.push_back(cyc); end
        if (valid_b) begin qb.push_back(int'(pxl_b)); tb.push_back(cyc); end
        if (valid_c) begin qc.push_back(int'(pxl_c)); tc.push_back(cyc); end
        if (done_a) begin dn_a <= dn_a + 1; dcyc_a <= cyc; bsy_a <= int'(busy_a); end
        if (done_b) begin dn_b <= dn_b + 1; dcyc_b <= cyc; end
        if (done_c) begin dn_c <= dn_c + 1; dcyc_c <= cyc; end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count then every pixel of a frame recorded from base index b.
    task automatic chk_frame(input string tag, input int q[$], input int b, input int n);
        chk({tag, "_count"}, q.size() - b, n);
        for (int i = 0; i < n && b + i < q.size(); i++)
            chk({tag, "_pxl"}, q[b + i], i);
    endtask

    function automatic int dcount(input int which);
        case (which)
            0: return dn_a;
            1: return dn_b;
            default: return dn_c;
        endcase
    endfunction

    task automatic wait_done(input int which, input int d0);
        for (int i = 0; i < 300 && dcount(which) == d0; i++) tick();
        chk("done_timeout", int'(dcount(which) > d0), 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int st, b, d0;

    initial begin
        reset = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        pause_a = 0; pause_b = 0; pause_c = 0;
        tick(); tick();
        chk("rst_rd_en", int'(rd_a), 0);
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_pxl", int'(pxl_a), 0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        reset = 1'b0;
        tick(); tick();

        // Plain frame
        b = qa.size(); d0 = dn_a;
        start_a = 1; st = cyc;
        tick();
        start_a = 0;
        chk("t1_busy_after_start", int'(busy_a), 1);
        wait_done(0, d0);
        chk_frame("t1", qa, b, 32);
        chk("t1_first_valid_cyc", ta[b] - st, 3);
        chk("t1_last_valid_cyc", ta[b + 31] - st, 34);
        chk("t1_done_cnt", dn_a - d0, 1);
        chk("t1_done_cyc", dcyc_a - st, 35);
        chk("t1_busy_at_done", bsy_a, 0);
        chk("t1_busy_idle", int'(busy_a), 0);

        // Pause for 5 cycles with address 6 next to issue
        b = qa.size(); d0 = dn_a;
        start_a = 1; st = cyc;
        tick();
        start_a = 0;
        repeat (6) tick();
        pause_a = 1;
        #1;
        chk("t3_addr_at_pause", int'(addr_a), 6);
        chk("t3_rd_en_paused", int'(rd_a), 0);
        repeat (5) tick();
        pause_a = 0;
        wait_done(0, d0);
        chk_frame("t3", qa, b, 32);
        chk("t3_pxl4_cyc", ta[b + 4] - st, 7);
        chk("t3_pxl5_cyc", ta[b + 5] - st, 8);
        chk("t3_pxl6_cyc", ta[b + 6] - st, 14);
        chk("t3_done_cnt", dn_a - d0, 1);
        chk("t3_done_cyc", dcyc_a - st, 40);

        // Second start mid-frame is ignored
        b = qa.size(); d0 = dn_a;
        start_a = 1; st = cyc;
        tick();
        start_a = 0;
        repeat (12) tick();
        start_a = 1;
        tick();
        start_a = 0;
        wait_done(0, d0);
        chk_frame("t4", qa, b, 32);
        chk("t4_done_cnt", dn_a - d0, 1);
        chk("t4_done_cyc", dcyc_a - st, 35);

        // Reset mid-frame, then a fresh frame
        b = qa.size(); d0 = dn_a;
        start_a = 1; st = cyc;
        tick();
        start_a = 0;
        repeat (22) tick();
        reset = 1'b1;
        #1;
        chk("t5_rd_en", int'(rd_a), 0);
        chk("t5_addr", int'(addr_a), 0);
        chk("t5_pxl", int'(pxl_a), 0);
        chk("t5_valid", int'(valid_a), 0);
        chk("t5_busy", int'(busy_a), 0);
        chk("t5_done", int'(done_a), 0);
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("t5_no_done", dn_a - d0, 0);
        chk("t5_partial_count", qa.size() - b, 20);
        b = qa.size(); d0 = dn_a;
        start_a = 1; st = cyc;
        tick();
        start_a = 0;
        wait_done(0, d0);
        chk_frame("t5_fresh", qa, b, 32);
        chk("t5_fresh_done_cnt", dn_a - d0, 1);

        // Gap of 3 cycles between channel planes
        b = qb.size(); d0 = dn_b;
        start_b = 1; st = cyc;
        tick();
        start_b = 0;
        wait_done(1, d0);
        chk_frame("t2", qb, b, 32);
        chk("t2_first_valid_cyc", tb[b] - st, 3);
        chk("t2_plane0_span", tb[b + 15] - tb[b], 15);
        chk("t2_gap", tb[b + 16] - tb[b + 15], 4);
        chk("t2_plane1_span", tb[b + 31] - tb[b + 16], 15);
        chk("t2_done_cnt", dn_b - d0, 1);
        chk("t2_done_cyc", dcyc_b - st, 38);

        // Single-pixel geometry
        b = qc.size(); d0 = dn_c;
        start_c = 1; st = cyc;
        tick();
        start_c = 0;
        wait_done(2, d0);
        chk_frame("t6", qc, b, 1);
        chk("t6_valid_cyc", tc[b] - st, 3);
        chk("t6_done_cnt", dn_c - d0, 1);
        chk("t6_done_cyc", dcyc_c - st, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
